// File: rtl/rv_defs_pkg.sv
// rtl/rv_defs_pkg.sv - shared RV32I encodings used by the fetch stage and the control decoder
package rv_defs;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_JAL  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;
  localparam logic [1:0] PC_SEL_BR   = 2'b11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - redirect decision, redirect target and misalignment flag from the EX stage
module npc_calc
  import rv_defs::*;
(
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic [1:0]  ex_pc_sel_i,
  input  logic        ex_br_cond_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_rs1_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic        take;
  logic [31:0] raw;

  always_comb begin
    take = 1'b0;
    raw  = ex_pc_i + ex_imm_i;
    case (ex_pc_sel_i)
      PC_SEL_JAL:  take = 1'b1;
      PC_SEL_JALR: begin
        take = 1'b1;
        raw  = (ex_rs1_i + ex_imm_i) & ~32'd1;
      end
      PC_SEL_BR:   take = ex_br_cond_i;
      default:     take = 1'b0;
    endcase
    redirect_o = take & ex_valid_i & ex_branch_i;
    // A halfword-aligned target is forced down to the enclosing word.
    misalign_o = redirect_o & raw[1];
    target_o   = raw[1] ? (raw & ~32'd3) : raw;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC register, IROM address, IF/ID register, boot/run/halt FSM
module fetch_unit
  import rv_defs::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic [1:0]  ex_pc_sel_i,
  input  logic        ex_br_cond_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_rs1_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_inst_o,
  output logic [6:0]  id_opcode_o,
  output logic [2:0]  id_func3_o,
  output logic [6:0]  id_func7_o,
  output logic        flush_ex_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] redirect_cnt_o
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic         mis_q, mis_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   boot_cnt_q, boot_cnt_d;

  logic         redirect;
  logic [31:0]  target;
  logic         target_mis;
  logic         fetch;

  npc_calc u_npc_calc (
    .ex_valid_i   (ex_valid_i),
    .ex_branch_i  (ex_branch_i),
    .ex_pc_sel_i  (ex_pc_sel_i),
    .ex_br_cond_i (ex_br_cond_i),
    .ex_pc_i      (ex_pc_i),
    .ex_imm_i     (ex_imm_i),
    .ex_rs1_i     (ex_rs1_i),
    .redirect_o   (redirect),
    .target_o     (target),
    .misalign_o   (target_mis)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    mis_d      = mis_q;
    cnt_d      = cnt_q;
    boot_cnt_d = boot_cnt_q;
    fetch      = 1'b0;

    if (redirect && state_q != FS_BOOT) begin
      pc_d       = target;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      cnt_d      = cnt_q + 32'd1;
      mis_d      = mis_q | target_mis;
      state_d    = FS_RUN;
    end else begin
      case (state_q)
        FS_BOOT: begin
          if (boot_cnt_q == BOOT_LAST) fetch = 1'b1;
          else                         boot_cnt_d = boot_cnt_q + 4'd1;
        end
        FS_HALT: begin
          if (!stall_i) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
          end
        end
        default: fetch = !stall_i;
      endcase
    end

    // A captured SYSTEM instruction parks the PC on itself until a redirect.
    if (fetch) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_inst_d  = inst_i;
      if (inst_opcode(inst_i) == OPC_SYSTEM) begin
        state_d = FS_HALT;
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = FS_RUN;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= FS_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= NOP_INST;
      mis_q      <= 1'b0;
      cnt_q      <= 32'd0;
      boot_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign inst_addr_o    = pc_q;
  assign id_valid_o     = id_valid_q;
  assign id_pc_o        = id_pc_q;
  assign id_pc4_o       = id_pc_q + 32'd4;
  assign id_inst_o      = id_inst_q;
  assign id_opcode_o    = id_inst_q[6:0];
  assign id_func3_o     = id_inst_q[14:12];
  assign id_func7_o     = id_inst_q[31:25];
  assign flush_ex_o     = redirect;
  assign halted_o       = (state_q == FS_HALT);
  assign misalign_o     = mis_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed scenarios plus randomized run against a reference model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          BOOT     = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] inst_addr_o, inst_i;
  logic        stall_i, ex_valid_i, ex_branch_i, ex_br_cond_i;
  logic [1:0]  ex_pc_sel_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_rs1_i;
  logic        id_valid_o, flush_ex_o, halted_o, misalign_o;
  logic [31:0] id_pc_o, id_pc4_o, id_inst_o, redirect_cnt_o;
  logic [6:0]  id_opcode_o, id_func7_o;
  logic [2:0]  id_func3_o;

  logic [31:0] irom [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 cpu_clk = ~cpu_clk;
  assign inst_i = irom[inst_addr_o[9:2]];

  fetch_unit #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_addr_o(inst_addr_o), .inst_i(inst_i),
    .stall_i(stall_i), .ex_valid_i(ex_valid_i), .ex_branch_i(ex_branch_i),
    .ex_pc_sel_i(ex_pc_sel_i), .ex_br_cond_i(ex_br_cond_i), .ex_pc_i(ex_pc_i),
    .ex_imm_i(ex_imm_i), .ex_rs1_i(ex_rs1_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_pc4_o(id_pc4_o), .id_inst_o(id_inst_o), .id_opcode_o(id_opcode_o),
    .id_func3_o(id_func3_o), .id_func7_o(id_func7_o), .flush_ex_o(flush_ex_o),
    .halted_o(halted_o), .misalign_o(misalign_o), .redirect_cnt_o(redirect_cnt_o)
  );

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid_i = 0; ex_branch_i = 0; ex_pc_sel_i = 2'b00; ex_br_cond_i = 0;
    ex_pc_i = 0; ex_imm_i = 0; ex_rs1_i = 0;
  endtask

  task automatic drive_ex(input logic [1:0] sel, input logic cond, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1);
    ex_valid_i = 1; ex_branch_i = 1; ex_pc_sel_i = sel; ex_br_cond_i = cond;
    ex_pc_i = pc; ex_imm_i = imm; ex_rs1_i = rs1;
  endtask

  task automatic test_reset();
    cpu_rst = 1; stall_i = 0; clear_ex();
    tick(); tick();
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", id_valid_o); end
    n_cmp++; if (id_pc_o !== 32'd0) begin n_bad++; $display("FAIL reset_id_pc: got %h want 0", id_pc_o); end
    n_cmp++; if (id_inst_o !== NOP) begin n_bad++; $display("FAIL reset_id_inst: got %h want %h", id_inst_o, NOP); end
    n_cmp++; if (inst_addr_o !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", inst_addr_o, RESET_PC); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %0b want 0", misalign_o); end
    n_cmp++; if (redirect_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", redirect_cnt_o); end
    n_cmp++; if (halted_o !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted_o); end
  endtask

  task automatic test_boot();
    cpu_rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < BOOT) begin
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL boot_idle[%0d]: got %0b want 0", k, id_valid_o); end
      end else begin
        n_cmp++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'((k - BOOT) * 4) || id_inst_o !== irom[k - BOOT]) begin
          n_bad++;
          $display("FAIL boot_seq[%0d]: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   k, id_valid_o, id_pc_o, id_inst_o, 32'((k - BOOT) * 4), irom[k - BOOT]);
        end
      end
    end
    n_cmp++; if (id_pc4_o !== 32'hC) begin n_bad++; $display("FAIL boot_pc4: got %h want c", id_pc4_o); end
  endtask

  task automatic test_stall();
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (id_pc_o !== 32'h8 || id_inst_o !== irom[2] || inst_addr_o !== 32'hC) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h addr=%h want pc=8 inst=%h addr=c",
                 k, id_pc_o, id_inst_o, inst_addr_o, irom[2]);
      end
    end
    stall_i = 0;
    tick();
    n_cmp++; if (id_pc_o !== 32'hC) begin n_bad++; $display("FAIL stall_release: got %h want c", id_pc_o); end
  endtask

  task automatic test_branch();
    drive_ex(2'b11, 1'b1, 32'h10, 32'h20, 32'h0); stall_i = 1;
    #1;
    n_cmp++; if (flush_ex_o !== 1'b1) begin n_bad++; $display("FAIL br_flush: got %0b want 1", flush_ex_o); end
    tick(); clear_ex(); stall_i = 0;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL br_bubble: got %0b want 0", id_valid_o); end
    n_cmp++; if (inst_addr_o !== 32'h30) begin n_bad++; $display("FAIL br_target: got %h want 30", inst_addr_o); end
    n_cmp++; if (redirect_cnt_o !== 32'd1) begin n_bad++; $display("FAIL br_cnt: got %0d want 1", redirect_cnt_o); end
    tick();
    n_cmp++; if (id_pc_o !== 32'h30 || id_valid_o !== 1'b1) begin n_bad++; $display("FAIL br_fetch: got pc=%h v=%0b want pc=30 v=1", id_pc_o, id_valid_o); end
    drive_ex(2'b11, 1'b0, 32'h10, 32'h20, 32'h0); stall_i = 1;
    #1;
    n_cmp++; if (flush_ex_o !== 1'b0) begin n_bad++; $display("FAIL br_nt_flush: got %0b want 0", flush_ex_o); end
    tick(); clear_ex(); stall_i = 0;
    n_cmp++; if (inst_addr_o !== 32'h34 || redirect_cnt_o !== 32'd1) begin n_bad++; $display("FAIL br_nt_hold: got addr=%h cnt=%0d want addr=34 cnt=1", inst_addr_o, redirect_cnt_o); end
  endtask

  task automatic test_jalr_misalign();
    drive_ex(2'b10, 1'b0, 32'h0, 32'h0, 32'h103);
    tick(); clear_ex();
    n_cmp++; if (inst_addr_o !== 32'h100) begin n_bad++; $display("FAIL jalr_target: got %h want 100", inst_addr_o); end
    n_cmp++; if (misalign_o !== 1'b1) begin n_bad++; $display("FAIL jalr_misalign: got %0b want 1", misalign_o); end
    tick(); tick(); tick();
    n_cmp++; if (misalign_o !== 1'b1 || id_pc_o !== 32'h108) begin n_bad++; $display("FAIL jalr_sticky: got mis=%0b pc=%h want mis=1 pc=108", misalign_o, id_pc_o); end
  endtask

  task automatic test_halt();
    drive_ex(2'b01, 1'b0, 32'h0, 32'h14, 32'h0);
    tick(); clear_ex();
    n_cmp++; if (inst_addr_o !== 32'h14) begin n_bad++; $display("FAIL halt_jal: got %h want 14", inst_addr_o); end
    tick();
    n_cmp++;
    if (id_inst_o !== EBREAK || id_opcode_o !== 7'h73 || halted_o !== 1'b1 || inst_addr_o !== 32'h14) begin
      n_bad++;
      $display("FAIL halt_enter: got inst=%h opc=%h halted=%0b addr=%h want inst=%h opc=73 halted=1 addr=14",
               id_inst_o, id_opcode_o, halted_o, inst_addr_o, EBREAK);
    end
    tick(); tick();
    n_cmp++;
    if (id_valid_o !== 1'b0 || inst_addr_o !== 32'h14 || halted_o !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_hold: got v=%0b addr=%h halted=%0b want v=0 addr=14 halted=1", id_valid_o, inst_addr_o, halted_o);
    end
    drive_ex(2'b01, 1'b0, 32'h30, 32'h10, 32'h0);
    tick(); clear_ex();
    n_cmp++; if (halted_o !== 1'b0 || inst_addr_o !== 32'h40) begin n_bad++; $display("FAIL halt_exit: got halted=%0b addr=%h want halted=0 addr=40", halted_o, inst_addr_o); end
    tick();
    n_cmp++; if (id_pc_o !== 32'h40 || id_valid_o !== 1'b1) begin n_bad++; $display("FAIL halt_resume: got pc=%h v=%0b want pc=40 v=1", id_pc_o, id_valid_o); end
  endtask

  task automatic test_reset_mid_run();
    drive_ex(2'b01, 1'b0, 32'h0, 32'h24, 32'h0);
    tick(); clear_ex();
    tick();
    n_cmp++; if (id_pc_o !== 32'h24) begin n_bad++; $display("FAIL rst_setup: got %h want 24", id_pc_o); end
    drive_ex(2'b01, 1'b0, 32'h0, 32'h80, 32'h0); cpu_rst = 1;
    tick(); clear_ex();
    n_cmp++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'd0 || id_inst_o !== NOP || inst_addr_o !== RESET_PC ||
        misalign_o !== 1'b0 || redirect_cnt_o !== 32'd0 || halted_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: got v=%0b pc=%h inst=%h addr=%h mis=%0b cnt=%0d halted=%0b want all reset values",
               id_valid_o, id_pc_o, id_inst_o, inst_addr_o, misalign_o, redirect_cnt_o, halted_o);
    end
    cpu_rst = 0;
    for (int k = 0; k <= BOOT; k++) begin
      tick();
      n_cmp++;
      if (id_valid_o !== (k == BOOT) || (k == BOOT && id_pc_o !== RESET_PC)) begin
        n_bad++;
        $display("FAIL rst_reboot[%0d]: got v=%0b pc=%h", k, id_valid_o, id_pc_o);
      end
    end
  endtask

  task automatic test_random();
    logic        m_booting, m_halt, m_valid, m_mis, r, tmis;
    int          m_boot_left;
    logic [31:0] m_pc, m_idpc, m_inst, m_cnt, t, fetched;

    cpu_rst = 1; stall_i = 0; clear_ex();
    tick();
    m_booting = 1; m_boot_left = BOOT; m_halt = 0; m_valid = 0; m_mis = 0;
    m_pc = RESET_PC; m_idpc = 0; m_inst = NOP; m_cnt = 0;
    cpu_rst = 0;
    for (int c = 0; c < 600; c++) begin
      cpu_rst     = ($urandom_range(0, 99) == 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      ex_valid_i  = !m_booting && ($urandom_range(0, 3) == 0);
      ex_branch_i = ($urandom_range(0, 4) != 0);
      ex_pc_sel_i = 2'($urandom_range(0, 3));
      ex_br_cond_i = 1'($urandom_range(0, 1));
      ex_pc_i     = $urandom & ~32'd3;
      ex_imm_i    = $urandom & ~32'd1;
      ex_rs1_i    = $urandom;
      #1;
      r = ex_valid_i && ex_branch_i &&
          (ex_pc_sel_i == 2'b01 || ex_pc_sel_i == 2'b10 || (ex_pc_sel_i == 2'b11 && ex_br_cond_i));
      if (ex_pc_sel_i == 2'b10) t = (ex_rs1_i + ex_imm_i) & ~32'd1;
      else                      t = ex_pc_i + ex_imm_i;
      tmis = t[1];
      if (tmis) t = t & ~32'd3;
      n_cmp++; if (flush_ex_o !== r) begin n_bad++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", c, flush_ex_o, r); end
      n_cmp++; if (inst_addr_o !== m_pc) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, inst_addr_o, m_pc); end
      tick();
      fetched = irom[m_pc[9:2]];
      if (cpu_rst) begin
        m_booting = 1; m_boot_left = BOOT; m_halt = 0; m_valid = 0; m_mis = 0;
        m_pc = RESET_PC; m_idpc = 0; m_inst = NOP; m_cnt = 0;
      end else if (r && !m_booting) begin
        m_pc = t; m_valid = 0; m_inst = NOP; m_cnt = m_cnt + 1; m_mis = m_mis | tmis; m_halt = 0;
      end else if (m_booting || (!m_halt && !stall_i)) begin
        if (m_booting && m_boot_left > 0) begin
          m_boot_left--;
        end else begin
          m_booting = 0;
          m_valid = 1; m_idpc = m_pc; m_inst = fetched;
          if (fetched[6:0] == 7'h73) m_halt = 1;
          else                       m_pc = m_pc + 4;
        end
      end else if (m_halt && !stall_i) begin
        m_valid = 0; m_inst = NOP;
      end
      n_cmp++; if (id_valid_o !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, id_valid_o, m_valid); end
      if (m_valid) begin
        n_cmp++; if (id_pc_o !== m_idpc) begin n_bad++; $display("FAIL rnd_id_pc[%0d]: got %h want %h", c, id_pc_o, m_idpc); end
      end
      n_cmp++; if (id_inst_o !== m_inst) begin n_bad++; $display("FAIL rnd_inst[%0d]: got %h want %h", c, id_inst_o, m_inst); end
      n_cmp++;
      if (id_opcode_o !== m_inst[6:0] || id_func3_o !== m_inst[14:12] || id_func7_o !== m_inst[31:25]) begin
        n_bad++;
        $display("FAIL rnd_fields[%0d]: got %h/%h/%h want %h/%h/%h", c, id_opcode_o, id_func3_o, id_func7_o,
                 m_inst[6:0], m_inst[14:12], m_inst[31:25]);
      end
      n_cmp++; if (halted_o !== m_halt) begin n_bad++; $display("FAIL rnd_halted[%0d]: got %0b want %0b", c, halted_o, m_halt); end
      n_cmp++; if (misalign_o !== m_mis) begin n_bad++; $display("FAIL rnd_misalign[%0d]: got %0b want %0b", c, misalign_o, m_mis); end
      n_cmp++; if (redirect_cnt_o !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, redirect_cnt_o, m_cnt); end
    end
    cpu_rst = 0; stall_i = 0; clear_ex();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) irom[i] = {$urandom_range(0, 32'h1FF_FFFF), 7'h13};
    irom[5]   = EBREAK;
    irom[37]  = 32'h0000_0073;
    irom[150] = EBREAK;
    cpu_rst = 1; stall_i = 0; clear_ex();
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    test_jalr_misalign();
    test_halt();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
